btn_event_scheduler: RTL
========================

Name: btn_event_scheduler

Overview:
- Conditions Nbtn raw, bouncing, asynchronous push-buttons: synchronise, debounce, detect press/release edges.
- Holds one pending event per button and shares a single byte-wide transmit channel (UART TX front end) among the buttons with a round-robin arbiter.
- Each granted event leaves as one byte on a valid/ready handshake.
- Sits between the board buttons (the button_pusher model in simulation) and the UART transmitter.

Parameters:
- Nbtn, 5, number of buttons; legal range 1..128.
- DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronised input must differ from the debounced level before the change is accepted; legal range >=2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  Nbtn  raw button levels, asynchronous, may bounce.
- btn_state  output  Nbtn  debounced button levels.
- tx_valid  output  1  tx_data holds an event byte.
- tx_ready  input  1  consumer accepts the byte when tx_valid&&tx_ready at a clk edge.
- tx_data  output  8  bit7 = 1 press / 0 release; bits6:0 = button index.
- event_drop  output  1  one-cycle pulse: an event was discarded because that button's slot was full.

Behaviour:
- Reset (rst_n low, asynchronous; released synchronously by the user) forces:
  - sync flops, btn_state, debounce counters, pending slots, RR pointer: all 0.
  - tx_valid=0, tx_data=0, event_drop=0, FSM=IDLE.
  - Reset mid-transfer drops the in-flight byte and all pending events.
- Synchroniser: 2 flops per bit; s[i] is the second flop.
- Debounce, per button:
  - If s[i]==btn_state[i], the counter clears to 0.
  - Otherwise the counter increments. On the edge where the counter equals DEBOUNCE_CYCLES-1:
    - btn_state[i] <= s[i] and the counter clears.
    - A one-cycle internal event ev[i] is raised with type = new level (1 press, 0 release).
  - Any bounce back to the old level before the threshold clears the counter; no event is generated.
- Pending slot, per button: valid bit plus type bit.
  - ev[i] with slot empty: slot loaded on the next edge.
  - ev[i] with slot full and not being granted this cycle: new event discarded, event_drop=1 for one cycle.
  - ev[i] in the same cycle the slot is granted: the slot is refilled with the new event, no drop.
  - Multiple drops in one cycle still give a single pulse.
- Arbiter FSM, 2 states:
  - IDLE: tx_valid=0. If any slot is valid, the next edge does all of the following:
    - Grants the first valid slot searching upward from pointer, wrapping at Nbtn-1 to 0.
    - Sets tx_data={type,7'(index)} and tx_valid=1.
    - Clears the slot and sets pointer=(index+1) mod Nbtn.
    - Moves to SEND.
  - SEND: tx_valid=1 and tx_data stable until the handshake. On tx_valid&&tx_ready: tx_valid<=0, state IDLE.
    - Exactly one IDLE cycle separates consecutive bytes.
    - tx_data keeps its last value in IDLE.
  - tx_ready low indefinitely: the byte is held, and at most one further event per button is queued.
- Latency:
  - Debounce threshold edge -> slot valid: +1 cycle.
  - Slot valid -> tx_valid: +1 cycle (IDLE, channel free).
  - Raw input change -> btn_state: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Fairness: every valid slot is granted within Nbtn grants.

Test Plan:
- Test parameters: DEBOUNCE_CYCLES=4, Nbtn=5, tx_ready tied 1 unless stated.
- Clean press: btn[2] 0->1 and held -> btn_state[2]=1 exactly 6 cycles later; single byte 0x82; after release, single byte 0x02; no event_drop.
- Bounce: btn[1] toggles every 2 cycles for 40 cycles, then settles at 1 -> no byte during bouncing; exactly one 0x81 after settling; btn_state[1] never glitches.
- Round-robin: buttons 0, 3, 4 press in the same cycle, pointer=0 -> bytes 0x80, 0x83, 0x84 in that order; next simultaneous press of 0 and 4 -> 0x80 first (pointer wrapped to 0).
- Back-pressure/overflow: tx_ready=0, btn[0] press then release then press (each debounced) -> first press in tx_data, release queued, second press drops with one event_drop pulse; on tx_ready=1 -> 0x80 then 0x00, nothing more.
- Handshake hold: tx_ready low for 10 cycles with tx_valid=1 -> tx_data constant; tx_ready high one cycle -> tx_valid low next edge.
- Reset mid-SEND: rst_n pulsed low while tx_valid=1 with slots pending -> tx_valid=0 and btn_state=0 immediately (async); no bytes emitted after release until new debounced edges occur.

Source files
------------

// File: rtl/btn_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// btn_event_scheduler_if
// Byte-wide valid/ready transmit channel between the button event scheduler
// and the UART transmitter front end.
// Revision: 1.0
// ============================================================================
interface btn_event_scheduler_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/btn_event_scheduler.sv
`default_nettype none
// ============================================================================
// btn_event_scheduler
// Synchronises and debounces Nbtn push-buttons, queues one press/release event
// per button and sends them one byte at a time under round-robin arbitration.
// Revision: 1.0
// ============================================================================
module btn_event_scheduler #(
  parameter int Nbtn            = 5,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic [Nbtn-1:0] btn,
  output logic      [Nbtn-1:0] btn_state,
  output logic                 event_drop,
  btn_event_scheduler_if.master tx
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int c_PTR_W = (Nbtn > 1) ? $clog2(Nbtn) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(Nbtn - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [Nbtn-1:0]    r_sync1;
  logic [Nbtn-1:0]    r_sync2;
  logic [Nbtn-1:0]    r_state;
  logic [Nbtn-1:0]    r_ev;
  logic [c_CNT_W-1:0] r_cnt [Nbtn];
  logic [Nbtn-1:0]    r_pend_v;
  logic [Nbtn-1:0]    r_pend_t;
  logic [c_PTR_W-1:0] r_ptr;
  state_t             r_fsm;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_drop;

  logic               w_grant_en;
  logic [c_PTR_W-1:0] w_grant_idx;
  logic [Nbtn-1:0]    w_grant_oh;
  logic [Nbtn-1:0]    w_load;
  logic               w_drop;
  int                 w_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // r_ev pulses on the same edge r_state takes its new level, so r_state is the event type
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_ev    <= '0;
      for (int i = 0; i < Nbtn; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_ev <= '0;
      for (int i = 0; i < Nbtn; i++) begin
        if (r_sync2[i] == r_state[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_MAX) begin
          r_state[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
          r_ev[i]    <= 1'b1;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_grant_en  = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    for (int k = 0; k < Nbtn; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= Nbtn) begin
        w_idx = w_idx - Nbtn;
      end
      if (!w_grant_en && r_pend_v[w_idx[c_PTR_W-1:0]]) begin
        w_grant_en  = 1'b1;
        w_grant_idx = w_idx[c_PTR_W-1:0];
      end
    end
    w_grant_en = w_grant_en && (r_fsm == IDLE);
    w_grant_oh = w_grant_en ? (Nbtn'(1) << w_grant_idx) : '0;
    // A slot being granted this cycle can take a new event without dropping it
    w_load     = r_ev & (~r_pend_v | w_grant_oh);
    w_drop     = |(r_ev & r_pend_v & ~w_grant_oh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v <= '0;
      r_pend_t <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_pend_v <= (r_pend_v & ~w_grant_oh) | r_ev;
      r_pend_t <= (r_pend_t & ~w_load) | (r_state & w_load);
      r_drop   <= w_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_ptr      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_grant_en) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= {r_pend_t[w_grant_idx], 7'(w_grant_idx)};
            r_ptr      <= (w_grant_idx == c_PTR_LAST) ? '0 : w_grant_idx + 1'b1;
            r_fsm      <= SEND;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_fsm      <= IDLE;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  assign btn_state   = r_state;
  assign event_drop  = r_drop;
  assign tx.tx_valid = r_tx_valid;
  assign tx.tx_data  = r_tx_data;

endmodule
`default_nettype wire
